// File: rtl/prio_encoder_n.sv
// prio_encoder_n: registered N-bit encoder with strict one-hot and
// highest-index-priority modes, a valid/ready handshake on both sides
// and a saturating count of strict-mode violations.
module prio_encoder_n #(
  parameter int N     = 8,
  parameter int CNT_W = 8,
  localparam int W    = ($clog2(N) > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  output logic [W-1:0]     out_idx,
  output logic             out_zero,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic         any_set;
  logic         multi_set;
  logic [W-1:0] hi_idx;
  logic         res_zero;
  logic         res_err;
  logic [W-1:0] res_idx;
  logic         in_xfer;

  // Scan upward so the last set bit seen is the highest index; any second
  // set bit marks the vector as non-one-hot.
  always_comb begin
    any_set   = 1'b0;
    multi_set = 1'b0;
    hi_idx    = '0;
    for (int k = 0; k < N; k++) begin
      if (in_data[k]) begin
        multi_set = multi_set | any_set;
        any_set   = 1'b1;
        hi_idx    = W'(k);
      end
    end
  end

  // Zero and strict-mode errors both force the index to 0.
  always_comb begin
    res_zero = ~any_set;
    res_err  = ~mode & multi_set;
    res_idx  = (res_zero | res_err) ? '0 : hi_idx;
  end

  // A single output stage: accept whenever it is empty or being drained.
  assign in_ready = ~out_valid | out_ready;
  assign in_xfer  = in_valid & in_ready;

  // Output register: load on accept, drop valid once drained with no refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_zero  <= 1'b0;
      out_err   <= 1'b0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_idx   <= res_idx;
      out_zero  <= res_zero;
      out_err   <= res_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating error counter; clear wins over a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (in_xfer && res_err && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_prio_encoder_n.sv
// Bench for prio_encoder_n: an N=8/CNT_W=2 and an N=5 instance driven in
// lockstep (the N=5 one sees the low five request bits), checked every
// cycle against a behavioural model plus directed literal expectations.
module tb_prio_encoder_n;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       in_valid, mode, out_ready, err_clr;

  logic       a_in_ready, a_out_zero, a_out_err, a_out_valid;
  logic [2:0] a_out_idx;
  logic [1:0] a_err_cnt;
  logic       b_in_ready, b_out_zero, b_out_err, b_out_valid;
  logic [2:0] b_out_idx;
  logic [7:0] b_err_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  prio_encoder_n #(.N(8), .CNT_W(2)) u8 (
    .clk(clk), .rst_n(rst_n), .in_data(din), .in_valid(in_valid),
    .in_ready(a_in_ready), .mode(mode), .out_idx(a_out_idx),
    .out_zero(a_out_zero), .out_err(a_out_err), .out_valid(a_out_valid),
    .out_ready(out_ready), .err_cnt(a_err_cnt), .err_clr(err_clr));

  prio_encoder_n #(.N(5), .CNT_W(8)) u5 (
    .clk(clk), .rst_n(rst_n), .in_data(din[4:0]), .in_valid(in_valid),
    .in_ready(b_in_ready), .mode(mode), .out_idx(b_out_idx),
    .out_zero(b_out_zero), .out_err(b_out_err), .out_valid(b_out_valid),
    .out_ready(out_ready), .err_cnt(b_err_cnt), .err_clr(err_clr));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules, computed from bit counts over the low n bits.
  function automatic int ones(input logic [7:0] v, input int n);
    int c = 0;
    for (int k = 0; k < n; k++) c += int'(v[k]);
    return c;
  endfunction

  function automatic int ref_idx(input logic [7:0] v, input logic m, input int n);
    int hi = 0;
    for (int k = 0; k < n; k++) if (v[k]) hi = k;
    if (ones(v, n) == 0) return 0;
    if (!m && ones(v, n) > 1) return 0;
    return hi;
  endfunction

  function automatic int ref_zero(input logic [7:0] v, input int n);
    return (ones(v, n) == 0) ? 1 : 0;
  endfunction

  function automatic int ref_err(input logic [7:0] v, input logic m, input int n);
    return (!m && ones(v, n) > 1) ? 1 : 0;
  endfunction

  // Model state: the result each instance should currently be presenting.
  logic m_valid;
  int   ma_idx, ma_zero, ma_err, ma_cnt;
  int   mb_idx, mb_zero, mb_err, mb_cnt;
  wire  m_accept = in_valid && (!m_valid || out_ready);

  // Model update: one result per accept; a drained, unrefilled stage empties.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      ma_idx <= 0; ma_zero <= 0; ma_err <= 0; ma_cnt <= 0;
      mb_idx <= 0; mb_zero <= 0; mb_err <= 0; mb_cnt <= 0;
    end else begin
      if (m_accept) begin
        m_valid <= 1'b1;
        ma_idx  <= ref_idx(din, mode, 8);
        ma_zero <= ref_zero(din, 8);
        ma_err  <= ref_err(din, mode, 8);
        mb_idx  <= ref_idx(din, mode, 5);
        mb_zero <= ref_zero(din, 5);
        mb_err  <= ref_err(din, mode, 5);
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
      if (err_clr) begin
        ma_cnt <= 0;
        mb_cnt <= 0;
      end else if (m_accept) begin
        ma_cnt <= (ma_cnt + ref_err(din, mode, 8) > 3)   ? 3   : ma_cnt + ref_err(din, mode, 8);
        mb_cnt <= (mb_cnt + ref_err(din, mode, 5) > 255) ? 255 : mb_cnt + ref_err(din, mode, 5);
      end
    end
  end

  // Compare process, on the falling edge away from input changes.
  always @(negedge clk) begin
    chk("a_valid", int'(a_out_valid), int'(m_valid));
    chk("b_valid", int'(b_out_valid), int'(m_valid));
    chk("a_in_ready", int'(a_in_ready), int'(!m_valid || out_ready));
    chk("b_in_ready", int'(b_in_ready), int'(!m_valid || out_ready));
    chk("a_err_cnt", int'(a_err_cnt), ma_cnt);
    chk("b_err_cnt", int'(b_err_cnt), mb_cnt);
    if (m_valid || !rst_n) begin
      chk("a_idx", int'(a_out_idx), ma_idx);
      chk("a_zero", int'(a_out_zero), ma_zero);
      chk("a_err", int'(a_out_err), ma_err);
      chk("b_idx", int'(b_out_idx), mb_idx);
      chk("b_zero", int'(b_out_zero), mb_zero);
      chk("b_err", int'(b_out_err), mb_err);
      chk("b_idx_range", int'(b_out_idx <= 3'd4), 1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v, input logic m);
    din = v; mode = m; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; din = '0; in_valid = 1'b0; mode = 1'b0;
    out_ready = 1'b1; err_clr = 1'b0;

    // Pin the reference functions themselves.
    chk("ref_h10", ref_idx(8'h10, 1'b0, 8), 4);
    chk("ref_h81_err", ref_err(8'h81, 1'b0, 8), 1);
    chk("ref_h81_idx0", ref_idx(8'h81, 1'b0, 8), 0);
    chk("ref_h81_pri", ref_idx(8'h81, 1'b1, 8), 7);
    chk("ref_zero", ref_zero(8'h00, 8), 1);
    chk("ref_n5_mask", ref_zero(8'he0, 5), 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(a_in_ready), 1);
    chk("rst_valid", int'(a_out_valid), 0);
    step();
    rst_n = 1'b1;

    // First edge after release accepts; one-cycle latency.
    send(8'h10, 1'b0);
    @(negedge clk);
    chk("d_h10_valid", int'(a_out_valid), 1);
    chk("d_h10_idx", int'(a_out_idx), 4);
    chk("d_h10_zero", int'(a_out_zero), 0);
    chk("d_h10_err", int'(a_out_err), 0);
    step();
    send(8'h81, 1'b0);
    @(negedge clk);
    chk("d_h81_err", int'(a_out_err), 1);
    chk("d_h81_idx", int'(a_out_idx), 0);
    chk("d_h81_cnt", int'(a_err_cnt), 1);
    step();
    send(8'h81, 1'b1);
    @(negedge clk);
    chk("d_h81p_idx", int'(a_out_idx), 7);
    chk("d_h81p_err", int'(a_out_err), 0);
    chk("d_h81p_cnt", int'(a_err_cnt), 1);
    step();
    for (int m = 0; m < 2; m++) begin
      send(8'h00, m[0]);
      @(negedge clk);
      chk("d_zero", int'(a_out_zero), 1);
      chk("d_zero_idx", int'(a_out_idx), 0);
      step();
    end

    // Saturation at 3 with CNT_W=2, then clear beats a coincident error.
    for (int i = 0; i < 5; i++) send(8'h03, 1'b0);
    @(negedge clk);
    chk("d_sat", int'(a_err_cnt), 3);
    step();
    err_clr = 1'b1;
    send(8'h06, 1'b0);
    err_clr = 1'b0;
    @(negedge clk);
    chk("d_clr", int'(a_err_cnt), 0);
    step();

    // Exhaustive N=5 sweep in both modes, back to back.
    for (int m = 0; m < 2; m++)
      for (int v = 0; v < 32; v++) begin
        din = {3'($urandom), 5'(v)}; mode = m[0]; in_valid = 1'b1;
        step();
      end
    in_valid = 1'b0;
    step();

    // Stall three cycles with a pending result and new input offered.
    send(8'h24, 1'b1);
    out_ready = 1'b0;
    din = 8'h01; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("d_stall_ready", int'(a_in_ready), 0);
      chk("d_stall_idx", int'(a_out_idx), 5);
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();

    // Asynchronous reset in the middle of a stall.
    send(8'h08, 1'b0);
    out_ready = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("d_arst_a_valid", int'(a_out_valid), 0);
    chk("d_arst_b_valid", int'(b_out_valid), 0);
    chk("d_arst_ready", int'(b_in_ready), 1);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("d_arst_no_stale", int'(a_out_valid), 0);

    // Randomized traffic with random backpressure and clears.
    for (int i = 0; i < 600; i++) begin
      din       = 8'($urandom);
      if (($urandom % 4) == 0) din = 8'(1 << ($urandom % 8));
      mode      = 1'($urandom);
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      err_clr   = ($urandom % 40) == 0;
      step();
    end
    in_valid = 1'b0; err_clr = 1'b0; out_ready = 1'b1;
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prio_encoder_n.md
PRIO_ENCODER_N -- requirements
Module: prio_encoder_n

Interface
REQ-001 The block SHALL have parameter N, default 8, input vector width; legal range 2..256.
REQ-002 The block SHALL have parameter CNT_W, default 8, error-counter width; legal range 1..32.
REQ-003 The block SHALL derive localparam W = max(1, clog2(N)) as the index width.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port in_data, input, N bits: request vector.
REQ-007 Port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-008 Port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-009 Port mode, input, 1 bit: 0 = strict one-hot, 1 = priority (highest index wins); sampled with each accepted input.
REQ-010 Port out_idx, output, W bits: encoded index of the selected bit.
REQ-011 Port out_zero, output, 1 bit: the accepted vector was all zeros.
REQ-012 Port out_err, output, 1 bit: the accepted vector had more than one bit set in strict mode.
REQ-013 Port out_valid, output, 1 bit: out_idx, out_zero and out_err are valid.
REQ-014 Port out_ready, input, 1 bit: downstream accepts the result.
REQ-015 Port err_cnt, output, CNT_W bits: saturating count of strict-mode errors.
REQ-016 Port err_clr, input, 1 bit: synchronous clear of err_cnt.

Function
REQ-017 An input transfer SHALL occur when in_valid and in_ready are both 1 on a rising clk edge; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-018 in_ready SHALL equal (!out_valid || out_ready): a single output register with no combinational in_valid-to-out_valid path.
REQ-019 Latency SHALL be exactly 1 cycle: a result is registered on the accepting edge, and out_valid is 1 from the following cycle.
REQ-020 out_valid SHALL be set on an input transfer, stay 1 while out_ready=0, and clear after an output transfer with no simultaneous input transfer.
REQ-021 On a simultaneous input transfer and output transfer, the output register SHALL load the new result and out_valid SHALL remain 1 (full throughput).
REQ-022 While out_valid=1 and out_ready=0, out_idx, out_zero and out_err SHALL hold stable.
REQ-023 Bit positions SHALL be 0-based: in_data[k] alone SHALL yield out_idx=k, out_zero=0, out_err=0.
REQ-024 An all-zero vector in either mode SHALL yield out_idx=0, out_zero=1, out_err=0.
REQ-025 In priority mode (mode=1) with several bits set, the block SHALL yield out_idx = highest set index, out_err=0.
REQ-026 In strict mode (mode=0) with two or more bits set, the block SHALL yield out_idx=0, out_zero=0, out_err=1.
REQ-027 err_cnt SHALL increment by 1 on each input transfer that produces out_err=1, and SHALL saturate at 2^CNT_W-1.
REQ-028 err_clr=1 SHALL set err_cnt to 0 on the next edge; it takes precedence over a simultaneous increment.
REQ-029 Inputs SHALL be ignored when in_valid=0, or when in_valid=1 and in_ready=0; no state changes in that case.
REQ-030 For N that is not a power of 2, out_idx SHALL never exceed N-1.

Reset
REQ-031 When rst_n=0, regardless of clk, the block SHALL set out_valid=0, out_idx=0, out_zero=0, out_err=0 and err_cnt=0.
REQ-032 Reset asserted mid-transfer SHALL discard the pending result, with no output transfer for it after release.
REQ-033 in_ready SHALL be 1 during and immediately after reset (follows from out_valid=0).
REQ-034 The first input transfer SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-035 N=8, mode=0, in_data=8'h10, out_ready=1 -> next cycle out_valid=1, out_idx=4, out_zero=0, out_err=0.
REQ-036 N=8, mode=0, in_data=8'h81 -> out_err=1, out_idx=0, err_cnt +1; same vector with mode=1 -> out_idx=7, out_err=0, err_cnt unchanged.
REQ-037 in_data=0 in both modes -> out_zero=1, out_idx=0, out_err=0.
REQ-038 Back-to-back stream with out_ready=1 -> one result per cycle; stall out_ready=0 for 3 cycles -> in_ready=0 and outputs stable; release -> no result lost or duplicated.
REQ-039 CNT_W=2: 5 strict-mode errors -> err_cnt saturates at 3; err_clr coinciding with an error -> err_cnt=0.
REQ-040 N=5: exhaustive 32-vector sweep in both modes against a reference model; assert rst_n mid-stall -> out_valid=0 asynchronously and in_ready=1.
